// File: rtl/brlite_local_injector.sv
// BrLite local-port injector: round-robin arbitration among local requesters,
// source/id stamping and the router's 4-phase local-port handshake with timeout.
package brlite_pkg;
  localparam int BR_ID_W = 8;

  localparam logic [1:0] BR_SVC_ALL   = 2'd0;
  localparam logic [1:0] BR_SVC_TGT   = 2'd1;
  localparam logic [1:0] BR_SVC_CLEAR = 2'd2;
  localparam logic [1:0] BR_SVC_MON   = 2'd3;

  typedef struct packed {
    logic [31:0]        payload;
    logic [15:0]        target;
    logic [15:0]        source;
    logic [BR_ID_W-1:0] id;
    logic [1:0]         service;
  } br_data_t;
endpackage

module brlite_local_injector
  import brlite_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  br_data_t           flit_i [NREQ],
  output logic [NREQ-1:0]    ack_o,
  output logic [NREQ-1:0]    err_o,
  output br_data_t           flit_o,
  output logic               req_o,
  input  logic               ack_i,
  input  logic               local_busy_i,
  output logic [BR_ID_W-1:0] next_id_o
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_WAIT,
    S_REQ,
    S_REL,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [SEL_W-1:0]   last_reg, last_next;
  br_data_t           flit_reg, flit_next;
  logic               err_reg, err_next;
  logic [BR_ID_W-1:0] id_reg, id_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;

  // Scan from farthest to nearest after last_reg so the nearest requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = last_reg;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      idx = (32'(last_reg) + i) % NREQ;
      if (req_i[SEL_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    flit_next  = flit_reg;
    err_next   = err_reg;
    id_next    = id_reg;
    cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (|req_i) state_next = S_ARB;
      end
      S_ARB: begin
        if (grant_vld) begin
          sel_next         = grant_idx;
          last_next        = grant_idx;
          flit_next        = flit_i[grant_idx];
          flit_next.source = ADDRESS;
          flit_next.id     = id_reg;
          // Only broadcast/targeted services may reach the router.
          if (flit_i[grant_idx].service != BR_SVC_ALL &&
              flit_i[grant_idx].service != BR_SVC_TGT) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!local_busy_i) begin
          state_next = S_REQ;
          cnt_next   = '0;
        end
      end
      S_REQ: begin
        if (ack_i) begin
          id_next    = id_reg + 1'b1;
          state_next = S_REL;
        end else if (TIMEOUT != 0 && cnt_reg == CNT_W'(TO_LAST)) begin
          // An aborted injection still burns its id.
          err_next   = 1'b1;
          id_next    = id_reg + 1'b1;
          state_next = S_REL;
        end
      end
      S_REL: begin
        if (!ack_i) state_next = S_DONE;
      end
      S_DONE: begin
        if (!req_i[sel_reg]) begin
          err_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      sel_reg   <= '0;
      last_reg  <= SEL_W'(NREQ - 1);
      flit_reg  <= '0;
      err_reg   <= 1'b0;
      id_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      flit_reg  <= flit_next;
      err_reg   <= err_next;
      id_reg    <= id_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign req_o     = (state_reg == S_REQ);
  assign flit_o    = flit_reg;
  assign next_id_o = id_reg;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
    assign ack_o[gi] = (state_reg == S_DONE) && (sel_reg == SEL_W'(gi));
    assign err_o[gi] = ack_o[gi] & err_reg;
  end

endmodule

// File: tb/tb_brlite_local_injector.sv
// Scoreboard bench for brlite_local_injector: a router model answers the local
// handshake and every ack_o rise is checked against the queued expectation.
module tb_brlite_local_injector;
  import brlite_pkg::*;

  localparam int          NREQ = 4;
  localparam logic [15:0] ADDR = 16'hA5C3;
  localparam int          TMO  = 16;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [NREQ-1:0]    req_i = '0;
  br_data_t           flit_i [NREQ];
  logic [NREQ-1:0]    ack_o;
  logic [NREQ-1:0]    err_o;
  br_data_t           flit_o;
  logic               req_o;
  logic               ack_i = 1'b0;
  logic               local_busy_i = 1'b0;
  logic [BR_ID_W-1:0] next_id_o;

  brlite_local_injector #(
    .NREQ   (NREQ),
    .ADDRESS(ADDR),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .flit_i      (flit_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .flit_o      (flit_o),
    .req_o       (req_o),
    .ack_i       (ack_i),
    .local_busy_i(local_busy_i),
    .next_id_o   (next_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int                 idx;
    logic [BR_ID_W-1:0] id;
    logic               err;
    logic [1:0]         svc;
    logic [31:0]        payload;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   pend_tot [NREQ];
  int   srv_cnt  [NREQ];
  int   rt_mode = 0;    // 0: hold ack until req drops, 1: one-cycle ack, 2: never ack
  int   rt_delay = 0;
  int   rt_cnt = 0;
  bit   pulsed = 0;
  int   reqhi_cnt = 0;
  logic [NREQ-1:0] ack_prev = '0;
  exp_t e;
  int   gidx;

  task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int idx, input int id, input bit err);
    exp_t x;
    x.idx     = idx;
    x.id      = BR_ID_W'(id);
    x.err     = err;
    x.svc     = flit_i[idx].service;
    x.payload = flit_i[idx].payload;
    sb_q.push_back(x);
  endfunction

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sb_q.size() != 0; c++) @(negedge clk_i);
    chk_vec("drain", 128'(sb_q.size()), 128'd0);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      pend_tot[k]         = 0;
      srv_cnt[k]          = 0;
      flit_i[k].payload   = 32'hC0DE_0000 + 32'(k);
      flit_i[k].target    = 16'(k);
      flit_i[k].source    = 16'hFFFF;
      flit_i[k].id        = 8'hEE;
      flit_i[k].service   = k[0] ? BR_SVC_TGT : BR_SVC_ALL;
    end

    fork
      // Requesters: raise while work is pending, drop on ack.
      forever begin
        @(posedge clk_i); #1;
        if (!rst_ni) req_i = '0;
        else begin
          for (int k = 0; k < NREQ; k++) begin
            if (req_i[k] && ack_o[k]) req_i[k] = 1'b0;
            else if (!req_i[k] && !ack_o[k] && srv_cnt[k] < pend_tot[k]) begin
              req_i[k] = 1'b1;
              srv_cnt[k]++;
            end
          end
        end
      end
      // Router local-port model.
      forever begin
        @(posedge clk_i); #1;
        if (!rst_ni) begin
          ack_i = 1'b0; rt_cnt = 0; pulsed = 0;
        end else begin
          case (rt_mode)
            0: begin
              if (!req_o) begin ack_i = 1'b0; rt_cnt = 0; end
              else if (!ack_i) begin
                if (rt_cnt >= rt_delay) ack_i = 1'b1;
                else rt_cnt++;
              end
            end
            1: begin
              if (ack_i) ack_i = 1'b0;
              else if (req_o && !pulsed) begin ack_i = 1'b1; pulsed = 1; end
              if (!req_o) pulsed = 0;
            end
            default: ack_i = 1'b0;
          endcase
        end
      end
      // Monitor: scoreboard pop on every ack_o rise.
      forever begin
        @(negedge clk_i);
        if (req_o) reqhi_cnt++;
        if (rst_ni && ack_o != '0 && ack_prev == '0) begin
          if (sb_q.size() == 0) chk_vec("sb_underflow", 128'(ack_o), 128'd0);
          else begin
            e    = sb_q.pop_front();
            gidx = -1;
            for (int k = 0; k < NREQ; k++) if (ack_o[k]) gidx = k;
            chk_vec("ack_onehot", 128'($countones(ack_o)), 128'd1);
            chk_vec("grant", 128'(gidx), 128'(e.idx));
            chk_vec("err_o", 128'(err_o), e.err ? 128'(1 << e.idx) : 128'd0);
            chk_vec("flit_id", 128'(flit_o.id), 128'(e.id));
            chk_vec("flit_src", 128'(flit_o.source), 128'(ADDR));
            chk_vec("flit_svc", 128'(flit_o.service), 128'(e.svc));
            chk_vec("flit_pay", 128'(flit_o.payload), 128'(e.payload));
            $display("txn req=%0d id=%0d err=%0b next_id=%0d", gidx, flit_o.id, err_o[e.idx], next_id_o);
          end
        end
        ack_prev = ack_o;
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk_i);
    chk_vec("rst_ack", 128'(ack_o), 128'd0);
    chk_vec("rst_err", 128'(err_o), 128'd0);
    chk_vec("rst_req", 128'(req_o), 128'd0);
    chk_vec("rst_flit", 128'(flit_o), 128'd0);
    chk_vec("rst_id", 128'(next_id_o), 128'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // All four requesting, router acks after 3 cycles: order 0,1,2,3,0.
    rt_mode = 0; rt_delay = 3;
    push_exp(0, 0, 0); push_exp(1, 1, 0); push_exp(2, 2, 0); push_exp(3, 3, 0); push_exp(0, 4, 0);
    pend_tot[0] += 2; pend_tot[1] += 1; pend_tot[2] += 1; pend_tot[3] += 1;
    wait_drain(300);
    chk_vec("t1_next_id", 128'(next_id_o), 128'd5);

    // CLEAR service: error, router untouched, id not consumed.
    flit_i[2].service = BR_SVC_CLEAR;
    reqhi_cnt = 0;
    push_exp(2, 5, 1);
    pend_tot[2] += 1;
    wait_drain(100);
    chk_vec("t2_req_quiet", 128'(reqhi_cnt), 128'd0);
    chk_vec("t2_next_id", 128'(next_id_o), 128'd5);
    flit_i[2].service = BR_SVC_ALL;

    // Router busy for 50 cycles holds off the request.
    local_busy_i = 1'b1;
    rt_delay = 0;
    reqhi_cnt = 0;
    push_exp(1, 5, 0);
    pend_tot[1] += 1;
    repeat (50) @(negedge clk_i);
    chk_vec("t3_busy_hold", 128'(reqhi_cnt), 128'd0);
    @(posedge clk_i); #1;
    local_busy_i = 1'b0;
    @(negedge clk_i);
    chk_vec("t3_req_pre", 128'(req_o), 128'd0);
    @(negedge clk_i);
    chk_vec("t3_req_rise", 128'(req_o), 128'd1);
    wait_drain(100);
    chk_vec("t3_next_id", 128'(next_id_o), 128'd6);

    // Router never acks: timeout after exactly TMO cycles of req_o.
    rt_mode = 2;
    reqhi_cnt = 0;
    push_exp(0, 6, 1);
    pend_tot[0] += 1;
    wait_drain(200);
    chk_vec("t4_req_cycles", 128'(reqhi_cnt), 128'(TMO));
    chk_vec("t4_next_id", 128'(next_id_o), 128'd7);

    // One-cycle duplicate-style ack, then run ids through the wrap.
    rt_mode = 1;
    reqhi_cnt = 0;
    push_exp(3, 7, 0);
    pend_tot[3] += 1;
    wait_drain(100);
    chk_vec("t5_req_cycles", 128'(reqhi_cnt), 128'd1);
    chk_vec("t5_next_id", 128'(next_id_o), 128'd8);
    for (int j = 8; j <= 256; j++) push_exp(3, j % 256, 0);
    pend_tot[3] += 249;
    wait_drain(5000);
    chk_vec("t5_wrap_id", 128'(next_id_o), 128'd1);

    // Asynchronous reset while in S_REQ.
    rt_mode = 2;
    pend_tot[1] += 1;
    for (int c = 0; c < 50 && !req_o; c++) @(negedge clk_i);
    chk_vec("t6_req_seen", 128'(req_o), 128'd1);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk_vec("t6_req", 128'(req_o), 128'd0);
    chk_vec("t6_ack", 128'(ack_o), 128'd0);
    chk_vec("t6_err", 128'(err_o), 128'd0);
    chk_vec("t6_flit", 128'(flit_o), 128'd0);
    chk_vec("t6_id", 128'(next_id_o), 128'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    rt_mode = 0; rt_delay = 0;
    push_exp(0, 0, 0); push_exp(1, 1, 0);
    pend_tot[0] += 1; pend_tot[1] += 1;
    wait_drain(200);
    chk_vec("t6_next_id", 128'(next_id_o), 128'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
